// File: rtl/ysyx_22041211_lsu_bus_pkg.sv
// Shared encodings for the load/store unit: operation types, exception causes,
// FSM states and per-store base byte masks.
package ysyx_22041211_lsu_bus_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;
    localparam logic [2:0] LD_LWU  = 3'd6;
    localparam logic [2:0] LD_LD   = 3'd7;

    localparam logic [2:0] ST_NONE = 3'd0;
    localparam logic [2:0] ST_SB   = 3'd1;
    localparam logic [2:0] ST_SH   = 3'd2;
    localparam logic [2:0] ST_SW   = 3'd3;
    localparam logic [2:0] ST_SD   = 3'd4;

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_LOAD_MIS  = 2'd1;
    localparam logic [1:0] CAUSE_STORE_MIS = 2'd2;
    localparam logic [1:0] CAUSE_BUS_ERR   = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    function automatic logic [7:0] store_base(input logic [2:0] st);
        case (st)
            ST_SB:   return STRB_B;
            ST_SH:   return STRB_H;
            ST_SW:   return STRB_W;
            ST_SD:   return STRB_D;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Combinational lane logic: misalignment/illegal-width check, store strobe and
// data shifting, and load byte extraction with sign/zero extension.
module ysyx_22041211_lsu_align
    import ysyx_22041211_lsu_bus_pkg::*;
#(
    parameter int DATA_LEN = 32,
    localparam int STRB_LEN = DATA_LEN / 8,
    localparam int OFF_W = $clog2(STRB_LEN)
)(
    input  logic [OFF_W-1:0]    off,
    input  logic [2:0]          load_type,
    input  logic [2:0]          store_type,
    input  logic [DATA_LEN-1:0] wdata,
    input  logic [DATA_LEN-1:0] rdata,
    output logic                is_store,
    output logic                is_load,
    output logic                misalign,
    output logic [STRB_LEN-1:0] wstrb,
    output logic [DATA_LEN-1:0] wdata_sh,
    output logic [DATA_LEN-1:0] load_data
);
    logic [DATA_LEN-1:0] rdata_sh;
    logic signed [7:0]   lb_s;
    logic signed [15:0]  lh_s;
    logic signed [31:0]  lw_s;

    // Out-of-range store codes behave as "no store", so a load can still go through.
    assign is_store = (store_type >= ST_SB) && (store_type <= ST_SD);
    assign is_load  = !is_store && (load_type != LD_NONE);

    always_comb begin
        misalign = 1'b0;
        if (is_store) begin
            case (store_type)
                ST_SH:   misalign = off[0];
                ST_SW:   misalign = (off[1:0] != 2'b00);
                ST_SD:   misalign = (DATA_LEN == 32) || (off != '0);
                default: misalign = 1'b0;
            endcase
        end else begin
            case (load_type)
                LD_LH, LD_LHU: misalign = off[0];
                LD_LW:         misalign = (off[1:0] != 2'b00);
                LD_LWU:        misalign = (DATA_LEN == 32) || (off[1:0] != 2'b00);
                LD_LD:         misalign = (DATA_LEN == 32) || (off != '0);
                default:       misalign = 1'b0;
            endcase
        end
    end

    assign wstrb    = is_store ? (STRB_LEN'(store_base(store_type)) << off) : '0;
    assign wdata_sh = wdata << {off, 3'b000};
    assign rdata_sh = rdata >> {off, 3'b000};

    assign lb_s = rdata_sh[7:0];
    assign lh_s = rdata_sh[15:0];
    assign lw_s = rdata_sh[31:0];

    always_comb begin
        case (load_type)
            LD_LB:   load_data = DATA_LEN'(lb_s);
            LD_LBU:  load_data = DATA_LEN'(rdata_sh[7:0]);
            LD_LH:   load_data = DATA_LEN'(lh_s);
            LD_LHU:  load_data = DATA_LEN'(rdata_sh[15:0]);
            LD_LW:   load_data = DATA_LEN'(lw_s);
            LD_LWU:  load_data = DATA_LEN'(rdata_sh[31:0]);
            default: load_data = rdata_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22041211_lsu_bus.sv
// Load/store unit between EXU and WBU with a variable-latency request/response
// memory port; one instruction in flight, valid/ready on both sides.
module ysyx_22041211_lsu_bus
    import ysyx_22041211_lsu_bus_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    localparam int STRB_LEN = DATA_LEN / 8
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                exu_valid_i,
    output logic                lsu_ready_o,
    input  logic [DATA_LEN-1:0] alu_result_i,
    input  logic [DATA_LEN-1:0] mem_wdata_i,
    input  logic [2:0]          load_type_i,
    input  logic [2:0]          store_type_i,
    input  logic                wd_i,
    input  logic [4:0]          wreg_i,
    input  logic [DATA_LEN-1:0] csr_wdata_i,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic                req_we_o,
    output logic [ADDR_LEN-1:0] req_addr_o,
    output logic [DATA_LEN-1:0] req_wdata_o,
    output logic [STRB_LEN-1:0] req_wstrb_o,
    input  logic                rsp_valid_i,
    input  logic [DATA_LEN-1:0] rsp_rdata_i,
    input  logic                rsp_err_i,
    output logic                lsu_valid_o,
    input  logic                wb_ready_i,
    output logic                wd_o,
    output logic [4:0]          wreg_o,
    output logic [DATA_LEN-1:0] wdata_o,
    output logic [DATA_LEN-1:0] csr_wdata_o,
    output logic                excp_o,
    output logic [1:0]          excp_cause_o
);
    localparam int OFF_W = $clog2(STRB_LEN);

    logic [1:0]          state_q;
    logic                excp_q;
    logic [1:0]          cause_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [DATA_LEN-1:0] csr_q;
    logic [DATA_LEN-1:0] res_q;
    logic [2:0]          ltype_q;
    logic [2:0]          stype_q;
    logic                wd_q;
    logic [4:0]          wreg_q;

    logic                in_idle, in_req, in_rsp, in_done, accept;
    logic [OFF_W-1:0]    cur_off;
    logic [2:0]          cur_ltype, cur_stype;
    logic                is_store, is_load, misalign;
    logic [STRB_LEN-1:0] wstrb;
    logic [DATA_LEN-1:0] wdata_sh, load_data;

    assign in_idle = (state_q == S_IDLE);
    assign in_req  = (state_q == S_REQ);
    assign in_rsp  = (state_q == S_RSP);
    assign in_done = (state_q == S_DONE);
    assign accept  = exu_valid_i && in_idle;

    // Decode straight from the inputs while idle so the accept cycle can pick the next state.
    assign cur_off   = in_idle ? alu_result_i[OFF_W-1:0] : addr_q[OFF_W-1:0];
    assign cur_ltype = in_idle ? load_type_i  : ltype_q;
    assign cur_stype = in_idle ? store_type_i : stype_q;

    ysyx_22041211_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
        .off        (cur_off),
        .load_type  (cur_ltype),
        .store_type (cur_stype),
        .wdata      (wdata_q),
        .rdata      (rsp_rdata_i),
        .is_store   (is_store),
        .is_load    (is_load),
        .misalign   (misalign),
        .wstrb      (wstrb),
        .wdata_sh   (wdata_sh),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            excp_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            case (state_q)
                S_IDLE: if (exu_valid_i) begin
                    state_q <= ((is_store || is_load) && !misalign) ? S_REQ : S_DONE;
                    excp_q  <= misalign;
                    cause_q <= !misalign ? CAUSE_NONE :
                               (is_store ? CAUSE_STORE_MIS : CAUSE_LOAD_MIS);
                end
                S_REQ: if (req_ready_i) state_q <= S_RSP;
                S_RSP: if (rsp_valid_i) begin
                    state_q <= S_DONE;
                    excp_q  <= rsp_err_i;
                    cause_q <= rsp_err_i ? CAUSE_BUS_ERR : CAUSE_NONE;
                end
                default: if (wb_ready_i) state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= alu_result_i[ADDR_LEN-1:0];
            wdata_q <= mem_wdata_i;
            csr_q   <= csr_wdata_i;
            ltype_q <= load_type_i;
            stype_q <= store_type_i;
            wd_q    <= wd_i;
            wreg_q  <= wreg_i;
            res_q   <= (is_store || is_load) ? '0 : alu_result_i;
        end else if (in_rsp && rsp_valid_i) begin
            res_q   <= (is_load && !rsp_err_i) ? load_data : '0;
        end
    end

    // Outputs are gated by state so they read as zero whenever they carry nothing.
    assign lsu_ready_o  = in_idle;
    assign req_valid_o  = in_req;
    assign req_we_o     = in_req && is_store;
    assign req_addr_o   = in_req ? (addr_q & ~ADDR_LEN'(STRB_LEN - 1)) : '0;
    assign req_wdata_o  = (in_req && is_store) ? wdata_sh : '0;
    assign req_wstrb_o  = in_req ? wstrb : '0;
    assign lsu_valid_o  = in_done;
    assign wd_o         = in_done && wd_q && !excp_q && !is_store;
    assign wreg_o       = in_done ? wreg_q : '0;
    assign wdata_o      = in_done ? res_q : '0;
    assign csr_wdata_o  = in_done ? csr_q : '0;
    assign excp_o       = in_done && excp_q;
    assign excp_cause_o = in_done ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_ysyx_22041211_lsu_bus.sv
// Bench for the LSU: drives a 32-bit and a 64-bit instance and checks every
// transaction against a byte-level reference model.
module tb_ysyx_22041211_lsu_bus;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdat;
        logic        excp;
        logic [1:0]  cause;
        logic        wd;
        logic [63:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic v32, v64;
    logic [63:0] alu, wdat, csr, rdata;
    logic [2:0]  lt, st;
    logic        wd;
    logic [4:0]  wreg;
    logic        req_ready, rsp_valid, rsp_err, wb_ready;
    logic        sel64;
    int total = 0;
    int bad = 0;

    logic        a_ready, a_rv, a_we, a_lv, a_wd, a_excp;
    logic [31:0] a_addr, a_rwd, a_wdata, a_csr;
    logic [3:0]  a_strb;
    logic [4:0]  a_wreg;
    logic [1:0]  a_cause;
    logic        b_ready, b_rv, b_we, b_lv, b_wd, b_excp;
    logic [31:0] b_addr;
    logic [63:0] b_rwd, b_wdata, b_csr;
    logic [7:0]  b_strb;
    logic [4:0]  b_wreg;
    logic [1:0]  b_cause;

    logic        o_ready, o_rv, o_we, o_lv, o_wd, o_excp;
    logic [31:0] o_addr;
    logic [63:0] o_rwd, o_wdata, o_csr;
    logic [7:0]  o_strb;
    logic [4:0]  o_wreg;
    logic [1:0]  o_cause;

    always #5 clk = ~clk;

    ysyx_22041211_lsu_bus #(.DATA_LEN(32), .ADDR_LEN(32)) dut32 (
        .clk(clk), .rst(rst), .exu_valid_i(v32), .lsu_ready_o(a_ready),
        .alu_result_i(alu[31:0]), .mem_wdata_i(wdat[31:0]), .load_type_i(lt),
        .store_type_i(st), .wd_i(wd), .wreg_i(wreg), .csr_wdata_i(csr[31:0]),
        .req_valid_o(a_rv), .req_ready_i(req_ready), .req_we_o(a_we),
        .req_addr_o(a_addr), .req_wdata_o(a_rwd), .req_wstrb_o(a_strb),
        .rsp_valid_i(rsp_valid), .rsp_rdata_i(rdata[31:0]), .rsp_err_i(rsp_err),
        .lsu_valid_o(a_lv), .wb_ready_i(wb_ready), .wd_o(a_wd), .wreg_o(a_wreg),
        .wdata_o(a_wdata), .csr_wdata_o(a_csr), .excp_o(a_excp), .excp_cause_o(a_cause)
    );

    ysyx_22041211_lsu_bus #(.DATA_LEN(64), .ADDR_LEN(32)) dut64 (
        .clk(clk), .rst(rst), .exu_valid_i(v64), .lsu_ready_o(b_ready),
        .alu_result_i(alu), .mem_wdata_i(wdat), .load_type_i(lt),
        .store_type_i(st), .wd_i(wd), .wreg_i(wreg), .csr_wdata_i(csr),
        .req_valid_o(b_rv), .req_ready_i(req_ready), .req_we_o(b_we),
        .req_addr_o(b_addr), .req_wdata_o(b_rwd), .req_wstrb_o(b_strb),
        .rsp_valid_i(rsp_valid), .rsp_rdata_i(rdata), .rsp_err_i(rsp_err),
        .lsu_valid_o(b_lv), .wb_ready_i(wb_ready), .wd_o(b_wd), .wreg_o(b_wreg),
        .wdata_o(b_wdata), .csr_wdata_o(b_csr), .excp_o(b_excp), .excp_cause_o(b_cause)
    );

    always_comb begin
        o_ready = sel64 ? b_ready : a_ready;
        o_rv    = sel64 ? b_rv    : a_rv;
        o_we    = sel64 ? b_we    : a_we;
        o_addr  = sel64 ? b_addr  : a_addr;
        o_strb  = sel64 ? b_strb  : {4'h0, a_strb};
        o_rwd   = sel64 ? b_rwd   : {32'h0, a_rwd};
        o_lv    = sel64 ? b_lv    : a_lv;
        o_wd    = sel64 ? b_wd    : a_wd;
        o_wreg  = sel64 ? b_wreg  : a_wreg;
        o_wdata = sel64 ? b_wdata : {32'h0, a_wdata};
        o_csr   = sel64 ? b_csr   : {32'h0, a_csr};
        o_excp  = sel64 ? b_excp  : a_excp;
        o_cause = sel64 ? b_cause : a_cause;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference: access size, alignment and lane placement worked out byte by byte.
    function automatic exp_t model(input logic w64, input logic [2:0] l, input logic [2:0] s,
                                   input logic [63:0] a, input logic [63:0] wv, input logic [63:0] rv,
                                   input logic err, input logic wen);
        exp_t e;
        int nb, size, off;
        logic is_st, is_ld, sgn, mis;
        logic [63:0] mask, v;
        e = '0;
        nb = w64 ? 8 : 4;
        mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        is_st = (s >= 3'd1) && (s <= 3'd4);
        is_ld = !is_st && (l != 3'd0);
        if (!is_st && !is_ld) begin
            e.res = a & mask;
            e.wd = wen;
            return e;
        end
        size = is_st ? (1 << (int'(s) - 1)) : (1 << ((int'(l) - 1) / 2));
        sgn = (l == 3'd1) || (l == 3'd3) || (l == 3'd5);
        mis = (size > nb) || (is_ld && l == 3'd6 && !w64) || ((int'(a[2:0]) % size) != 0);
        if (mis) begin
            e.excp = 1'b1;
            e.cause = is_st ? 2'd2 : 2'd1;
            return e;
        end
        off = int'(a[2:0]) % nb;
        e.req = 1'b1;
        e.we = is_st;
        e.addr = a[31:0] - 32'(off);
        if (is_st) begin
            e.strb = 8'(((1 << size) - 1) << off);
            e.wdat = (wv << (8 * off)) & mask;
        end
        if (err) begin
            e.excp = 1'b1;
            e.cause = 2'd3;
            return e;
        end
        if (is_ld) begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = rv[8*(off+i) +: 8];
            if (sgn && v[8*size-1]) for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
            e.res = v & mask;
            e.wd = wen;
        end
        return e;
    endfunction

    task automatic do_op(input logic w64, input logic [2:0] t_lt, input logic [2:0] t_st,
                         input logic [63:0] t_a, input logic [63:0] t_wd, input logic [63:0] t_rd,
                         input logic t_err, input logic t_wen, input int req_dly, input int rsp_dly,
                         input int wb_dly, input string tag);
        exp_t e;
        logic [4:0] t_wreg;
        logic [63:0] t_csr, mask;
        int n;
        e = model(w64, t_lt, t_st, t_a, t_wd, t_rd, t_err, t_wen);
        mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        t_wreg = 5'($urandom_range(0, 31));
        t_csr = {$urandom, $urandom};
        @(negedge clk);
        sel64 = w64;
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/ready"}, 64'(o_ready), 64'd1);
        alu = t_a; wdat = t_wd; lt = t_lt; st = t_st; wd = t_wen; wreg = t_wreg; csr = t_csr;
        if (w64) v64 = 1'b1; else v32 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0; v64 = 1'b0;
        alu = {$urandom, $urandom}; wdat = {$urandom, $urandom};
        lt = 3'($urandom_range(0, 7)); st = 3'($urandom_range(0, 4));
        wd = ~t_wen; wreg = ~t_wreg; csr = ~t_csr;
        @(negedge clk);
        if (e.req) begin
            for (int i = 0; i <= req_dly; i++) begin
                check({tag, "/req_valid"}, 64'(o_rv), 64'd1);
                check({tag, "/req_we"}, 64'(o_we), 64'(e.we));
                check({tag, "/req_addr"}, 64'(o_addr), 64'(e.addr));
                check({tag, "/req_wstrb"}, 64'(o_strb), 64'(e.strb));
                check({tag, "/req_wdata"}, o_rwd, e.wdat);
                check({tag, "/busy"}, 64'({o_ready, o_lv}), 64'd0);
                if (i == req_dly) begin
                    req_ready = 1'b1;
                    // A response in the handshake cycle must be ignored.
                    if (rsp_dly > 0) begin
                        rsp_valid = 1'b1; rsp_err = 1'b1; rdata = ~t_rd;
                    end
                end
                @(negedge clk);
            end
            req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
            check({tag, "/rsp_wait"}, 64'({o_rv, o_lv}), 64'd0);
            repeat (rsp_dly) @(negedge clk);
            rsp_valid = 1'b1; rdata = t_rd; rsp_err = t_err;
            @(negedge clk);
            rsp_valid = 1'b0; rsp_err = 1'b0; rdata = {$urandom, $urandom};
        end else begin
            check({tag, "/no_req"}, 64'(o_rv), 64'd0);
        end
        for (int i = 0; i <= wb_dly; i++) begin
            check({tag, "/lsu_valid"}, 64'(o_lv), 64'd1);
            check({tag, "/lsu_ready"}, 64'(o_ready), 64'd0);
            check({tag, "/wd"}, 64'(o_wd), 64'(e.wd));
            check({tag, "/wreg"}, 64'(o_wreg), 64'(t_wreg));
            check({tag, "/csr"}, o_csr, t_csr & mask);
            check({tag, "/excp"}, 64'(o_excp), 64'(e.excp));
            check({tag, "/cause"}, 64'(o_cause), 64'(e.cause));
            if (!e.excp && !(e.req && e.we)) check({tag, "/wdata"}, o_wdata, e.res);
            if (i == wb_dly) wb_ready = 1'b1;
            @(negedge clk);
        end
        wb_ready = 1'b0;
        check({tag, "/back_idle"}, 64'({o_ready, o_lv}), 64'b10);
    endtask

    initial begin
        rst = 1'b1;
        v32 = 1'b0; v64 = 1'b0; sel64 = 1'b0;
        alu = '0; wdat = '0; csr = '0; rdata = '0; lt = '0; st = '0; wd = 1'b0; wreg = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; wb_ready = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel64 = k[0];
            #1;
            check("reset/ready", 64'(o_ready), 64'd1);
            check("reset/outs", {o_rv, o_we, o_lv, o_wd, o_excp, o_cause, o_wreg, o_strb}, 64'd0);
            check("reset/data", o_wdata | o_csr | o_rwd | 64'(o_addr), 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        do_op(1'b0, 3'd0, 3'd0, 64'h1234, 64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, "alu");
        do_op(1'b0, 3'd1, 3'd0, 64'h8000_0003, 64'h0, 64'h8000_0000, 1'b0, 1'b1, 0, 0, 0, "lb");
        do_op(1'b0, 3'd2, 3'd0, 64'h8000_0003, 64'h0, 64'h8000_0000, 1'b0, 1'b1, 1, 1, 0, "lbu");
        do_op(1'b0, 3'd0, 3'd2, 64'h102, 64'hABCD, 64'h0, 1'b0, 1'b1, 4, 0, 0, "sh");
        do_op(1'b0, 3'd5, 3'd0, 64'h101, 64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, "lw_mis");
        do_op(1'b0, 3'd5, 3'd0, 64'h100, 64'h0, 64'h5555_AAAA, 1'b1, 1'b1, 0, 2, 0, "lw_err");
        do_op(1'b0, 3'd7, 3'd0, 64'h10, 64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, "ld32");
        do_op(1'b0, 3'd6, 3'd0, 64'h14, 64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, "lwu32");
        do_op(1'b0, 3'd0, 3'd4, 64'h10, 64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, "sd32");
        do_op(1'b0, 3'd3, 3'd1, 64'h203, 64'h5A, 64'h0, 1'b0, 1'b1, 0, 0, 0, "st_prio");
        do_op(1'b1, 3'd7, 3'd0, 64'h10, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 1'b1, 0, 0, 3, "ld64");
        do_op(1'b1, 3'd6, 3'd0, 64'h14, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 1'b1, 2, 1, 0, "lwu64");
        do_op(1'b1, 3'd5, 3'd0, 64'h14, 64'h0, 64'h8122_3344_5566_7788, 1'b0, 1'b1, 0, 0, 0, "lw64");
        do_op(1'b1, 3'd0, 3'd4, 64'h18, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0, 1'b1, 1, 0, 0, "sd64");
        do_op(1'b1, 3'd0, 3'd3, 64'h1C, 64'hCAFE_F00D, 64'h0, 1'b0, 1'b1, 0, 0, 0, "sw64");
        do_op(1'b1, 3'd7, 3'd0, 64'h1C, 64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, "ld64_mis");

        for (int k = 0; k < 60; k++) begin
            logic        w, en, er;
            logic [2:0]  l, s;
            logic [63:0] a;
            w  = 1'($urandom_range(0, 1));
            l  = 3'($urandom_range(0, 7));
            s  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) a[2:0] = 3'd0;
            en = 1'($urandom_range(0, 1));
            er = ($urandom_range(0, 5) == 0);
            do_op(w, l, s, a, {$urandom, $urandom}, {$urandom, $urandom}, er, en,
                  $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), "rnd");
        end

        // Reset during REQ: the request must drop without waiting for a clock edge.
        @(negedge clk);
        sel64 = 1'b0; alu = 64'h200; lt = 3'd5; st = 3'd0; v32 = 1'b1;
        @(posedge clk);
        #1 v32 = 1'b0;
        @(negedge clk);
        check("rst_req/pre", 64'(o_rv), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_req/req_valid", 64'(o_rv), 64'd0);
        check("rst_req/ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // Reset during RSP: a response arriving afterwards must not produce a result.
        @(negedge clk);
        alu = 64'h204; lt = 3'd5; v32 = 1'b1;
        @(posedge clk);
        #1 v32 = 1'b0;
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check("rst_rsp/pre", 64'({o_rv, o_ready}), 64'd0);
        #2 rst = 1'b0;
        #1;
        check("rst_rsp/ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1; rsp_valid = 1'b1; rdata = 64'h1234_5678;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("rst_rsp/late", 64'({o_lv, o_ready}), 64'b01);
        @(negedge clk);
        check("rst_rsp/late2", 64'({o_lv, o_ready, o_rv}), 64'b010);
        do_op(1'b0, 3'd4, 3'd0, 64'h206, 64'h0, 64'hF00D_0000, 1'b0, 1'b1, 0, 0, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041211_lsu_bus.md
Name: ysyx_22041211_lsu_bus

Overview:
Parametrised load/store unit between EXU and WBU. It replaces the fixed-latency internal data SRAM access with a variable-latency request/response memory port. Adds byte-lane alignment, misalignment and bus-error reporting, and 64-bit operation. Uses valid/ready handshakes upstream (EXU) and downstream (WBU), with one instruction in flight.

Parameters:
DATA_LEN, 32, datapath/bus data width; legal values 32 or 64
ADDR_LEN, 32, address width
STRB_LEN, DATA_LEN/8, byte-strobe width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
exu_valid_i  in  1  EXU presents an instruction
lsu_ready_o  out  1  LSU can accept an instruction
alu_result_i  in  DATA_LEN  effective address / ALU result
mem_wdata_i  in  DATA_LEN  store data (LSB-aligned)
load_type_i  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD
store_type_i  in  3  0 none, 1 SB, 2 SH, 3 SW, 4 SD
wd_i  in  1  register write enable
wreg_i  in  5  destination register
csr_wdata_i  in  DATA_LEN  CSR write data, passed through
req_valid_o  out  1  memory request valid
req_ready_i  in  1  memory accepts request
req_we_o  out  1  1 = write
req_addr_o  out  ADDR_LEN  address, aligned down to STRB_LEN bytes
req_wdata_o  out  DATA_LEN  lane-shifted write data
req_wstrb_o  out  STRB_LEN  byte strobes (0 for reads)
rsp_valid_i  in  1  response valid
rsp_rdata_i  in  DATA_LEN  read data, full bus word
rsp_err_i  in  1  bus error, qualified by rsp_valid_i
lsu_valid_o  out  1  result valid to WBU
wb_ready_i  in  1  WBU accepts result
wd_o  out  1  register write enable
wreg_o  out  5  destination register
wdata_o  out  DATA_LEN  writeback data
csr_wdata_o  out  DATA_LEN  CSR data
excp_o  out  1  exception flag, valid with lsu_valid_o
excp_cause_o  out  2  0 none, 1 load misaligned, 2 store misaligned, 3 bus error

Behaviour:
- Reset: state IDLE; every output 0 except lsu_ready_o = 1. Reset asserted mid-transaction aborts at once: req_valid_o drops asynchronously, the instruction is lost, and a late rsp_valid_i is ignored.
- FSM states IDLE, REQ, RSP, DONE. lsu_ready_o = (state == IDLE).
- Accept on exu_valid_i && lsu_ready_o: register all inputs; decoded operation stays stable until IDLE.
- IDLE -> DONE when load_type = 0 and store_type = 0. wdata_o = alu_result_i; latency is 1 cycle from accept to lsu_valid_o.
- IDLE -> DONE when misaligned (H on odd address; W not 4-aligned; D not 8-aligned). excp_o = 1, cause 1 or 2, wd_o = 0, no bus request.
- IDLE -> REQ for a legal memory op. req_valid_o is held high in REQ and all req_* stay stable until req_ready_i. REQ -> RSP on req_ready_i.
- RSP -> DONE on rsp_valid_i. If rsp_err_i = 1: excp_o = 1, cause 3, wd_o = 0.
- Combinational response path: rsp_valid_i in the same cycle as req_ready_i is not honoured. The response is sampled only in RSP, so the minimum memory op latency is 3 cycles accept->lsu_valid_o.
- DONE: lsu_valid_o = 1, all outputs stable. DONE -> IDLE on wb_ready_i. The next accept can occur the cycle after.
- LD, LWU and SD at DATA_LEN = 32 are illegal: excp_o = 1, cause 1 or 2, no request.
- Lane rules, off = addr[log2(STRB_LEN)-1:0]:
  - req_wstrb_o = base mask << off, with base SB 0x1, SH 0x3, SW 0xF, SD 0xFF.
  - req_wdata_o = mem_wdata_i << (8*off).
  - Load data = rsp_rdata_i >> (8*off), then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to DATA_LEN. LW at 32 bits needs no extension.
- Both load_type_i and store_type_i nonzero: store takes priority. Load is ignored, wd_o forced 0.
- excp_o and excp_cause_o are 0 in every case not listed above.

Decomposition:
- Add to ysyx_22041211_define.v: load/store type encodings, exception cause codes, FSM state encodings, base strobe masks.
- One sub-module, ysyx_22041211_lsu_align: combinational misalign check, strobe/wdata shifting, and load extraction/extension, parametrised by DATA_LEN.

Test Plan:
- ALU op, alu_result = 0x1234, wd = 1, wreg = 5, wb_ready = 1 -> lsu_valid_o one cycle after accept, wdata_o = 0x1234, no req_valid_o.
- LB at addr 0x8000_0003, rsp_rdata 0x8000_0000 (DATA_LEN 32) -> req_addr 0x8000_0000, wdata_o 0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH at 0x102, wdata 0xABCD, req_ready held 0 for 4 cycles -> req_* stable throughout, wstrb 0xC, req_wdata 0xABCD_0000, wd_o = 0.
- LW at 0x101 -> no request, excp_o = 1, cause 1, lsu_valid_o after 1 cycle. Load with rsp_err_i = 1 -> cause 3, wd_o = 0.
- DATA_LEN 64: LD at 0x10, rsp 0x1122_3344_5566_7788 -> wdata_o equals rsp. LWU at 0x14 -> 0x0000_0000_1122_3344.
- wb_ready_i low for 3 cycles in DONE -> outputs held, lsu_ready_o = 0. Then rst pulsed low during RSP -> req_valid_o = 0 immediately, later response ignored, IDLE with lsu_ready_o = 1.
